// File: rtl/sipo_pkg.sv
// Shared types for the SIPO deserializer: output-buffer state encoding and
// the bit-counter width helper.
package sipo_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    // Sized for N+1 so the same counter fits a frame with or without a parity bit.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register, bit counter and frame_sync handling; pulses word_done with the
// completed word. SIPO_PARITY_EN adds a trailing even-parity bit to each frame.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         serial_in,
    input  logic         shift_en,
    input  logic         frame_sync,
    output logic         busy,
    output logic         word_done,
    output logic [N-1:0] word
`ifdef SIPO_PARITY_EN
    ,
    output logic         word_parity
`endif
);

    localparam int CW = cnt_width(N);
`ifdef SIPO_PARITY_EN
    localparam int F = N + 1;
`else
    localparam int F = N;
`endif
    localparam logic [CW-1:0] LAST = CW'(F - 1);

    logic [N-1:0]  shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_bit;

    assign last_bit = (cnt_q == LAST);
    assign busy     = (cnt_q != '0);

    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        word_done = 1'b0;
        if (shift_en) begin
            if (frame_sync) begin
                shift_d = {serial_in, {(N-1){1'b0}}};
                cnt_d   = CW'(1);
            end else if (last_bit) begin
                cnt_d     = '0;
                word_done = 1'b1;
`ifndef SIPO_PARITY_EN
                shift_d   = {serial_in, shift_q[N-1:1]};
`endif
            end else begin
                shift_d = {serial_in, shift_q[N-1:1]};
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SIPO_PARITY_EN
    // The data bits are already in place when the parity bit arrives.
    assign word        = shift_q;
    assign word_parity = serial_in;
`else
    logic unused_lsb;
    assign word       = {serial_in, shift_q[N-1:1]};
    assign unused_lsb = shift_q[0];
`endif

endmodule

// File: rtl/sipo_deserializer.sv
// SIPO deserializer top: one-entry output buffer with valid/ready, sticky overflow
// and optional parity check (enabled by defining SIPO_PARITY_EN).
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         serial_in,
    input  logic         shift_en,
    input  logic         frame_sync,
    input  logic         out_ready,
    input  logic         overflow_clr,
    output logic [N-1:0] parallel_out,
    output logic         out_valid,
    output logic         busy,
    output logic         overflow,
    output logic         parity_err
);

    logic         word_done;
    logic [N-1:0] word;
    out_state_e   state_q, state_d;
    logic [N-1:0] data_q, data_d;
    logic         ovf_q, ovf_d;
    logic         load, ovf_set;
`ifdef SIPO_PARITY_EN
    logic         word_parity;
    logic         perr_q, perr_d;
`endif

    sipo_shift_core #(.N(N)) u_core (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .shift_en   (shift_en),
        .frame_sync (frame_sync),
        .busy       (busy),
        .word_done  (word_done),
        .word       (word)
`ifdef SIPO_PARITY_EN
        ,
        .word_parity(word_parity)
`endif
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        ovf_set = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (word_done) begin
                    load    = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    load    = word_done;
                    state_d = word_done ? FULL : EMPTY;
                end else begin
                    ovf_set = word_done;
                end
            end
            default: state_d = EMPTY;
        endcase
        data_d = load ? word : data_q;
        ovf_d  = overflow_clr ? 1'b0 : (ovf_q | ovf_set);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef SIPO_PARITY_EN
    // A dropped word never reaches this register, so its parity is ignored too.
    assign perr_d = load ? ((^word) ^ word_parity) : perr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign parallel_out = data_q;
    assign out_valid    = (state_q == FULL);
    assign overflow     = ovf_q;

endmodule
